r8_result_collector: RTL and testbench

//   Receiving end of the R8 window-pipeline output stream. Accepts valid-qualified result

---
 rtl/r8_result_collector_pkg.sv | 17 +
 rtl/r8_result_collector_if.sv | 30 +++
 rtl/r8_result_collector_addr_counter.sv | 63 ++++++
 rtl/r8_result_collector.sv | 105 ++++++++++
 tb/tb_r8_result_collector.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/r8_result_collector_pkg.sv
// Shared types and helpers for the R8 result collector: FSM state encoding and frame sizing.
package r8_result_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_READY   = 2'd3
   } state_t;

   localparam int POS_W = 10;

   function automatic int frame_pixels(input int cols, input int rows);
      return cols * rows;
   endfunction

endpackage

// File: rtl/r8_result_collector_if.sv
// Pixel-stream input, frame-buffer write port and host handshake of the R8 result collector.
interface r8_result_collector_if
   import r8_result_collector_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              frame_end_i;
   logic              ack_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;
   logic [POS_W-1:0]  col_o;
   logic [POS_W-1:0]  row_o;
   logic              frame_ready_o;
   logic              err_o;
   logic              busy_o;

   modport slave (
      input  valid_i, data_i, frame_end_i, ack_i,
      output wr_en_o, wr_addr_o, wr_data_o, col_o, row_o, frame_ready_o, err_o, busy_o
   );

   modport master (
      output valid_i, data_i, frame_end_i, ack_i,
      input  wr_en_o, wr_addr_o, wr_data_o, col_o, row_o, frame_ready_o, err_o, busy_o
   );
endinterface

// File: rtl/r8_result_collector_addr_counter.sv
// Raster position tracker: col/row of the next pixel plus a linear address that needs no multiplier.
module r8_result_collector_addr_counter
   import r8_result_collector_pkg::*;
#(
   parameter int COLS   = 19,
   parameter int ROWS   = 19,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [POS_W-1:0]  col_o,
   output logic [POS_W-1:0]  row_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o,
   output logic              full_o
);
   localparam int FRAME_PIXELS = frame_pixels(COLS, ROWS);
   // One spare bit so a completely filled buffer is still distinguishable from address 0.
   localparam int CNT_W = ADDR_W + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [POS_W-1:0] col_q, col_d, row_q, row_d;

   assign full_o = (cnt_q == CNT_W'(FRAME_PIXELS));
   assign last_o = (cnt_q == CNT_W'(FRAME_PIXELS - 1));

   always_comb begin
      cnt_d = cnt_q;
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         cnt_d = '0;
         col_d = '0;
         row_d = '0;
      end else if (inc_i && !full_o) begin
         cnt_d = cnt_q + 1'b1;
         if (col_q == POS_W'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign addr_o = cnt_q[ADDR_W-1:0];
endmodule

// File: rtl/r8_result_collector.sv
// R8 result collector: writes the result pixel stream raster-order into a frame buffer,
// flags wrongly sized frames and holds frame-ready until the host acknowledges.
//   state   | meaning
//   IDLE    | waiting for the first pixel of a frame
//   COLLECT | accepting pixels until end-of-frame
//   DRAIN   | last registered write retiring
//   READY   | frame buffered, waiting for host ack
module r8_result_collector
   import r8_result_collector_pkg::*;
#(
   parameter int COLS   = 19,
   parameter int ROWS   = 19,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   r8_result_collector_if.slave bus
);
   if ((2 ** ADDR_W) < frame_pixels(COLS, ROWS)) begin : g_addr_check
      $error("r8_result_collector: ADDR_W too small for COLS*ROWS");
   end

   state_t            state_q, state_d;
   logic              err_q, err_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              accept, clr;
   logic              full, last;
   logic [ADDR_W-1:0] addr;

   r8_result_collector_addr_counter #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .inc_i  (accept),
      .col_o  (bus.col_o),
      .row_o  (bus.row_o),
      .addr_o (addr),
      .last_o (last),
      .full_o (full)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      accept  = 1'b0;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            accept = bus.valid_i && !full;
            if (bus.valid_i && full) err_d = 1'b1;
            if (bus.frame_end_i) begin
               state_d = ST_DRAIN;
               // Size check counts a pixel accepted in the same cycle as end-of-frame.
               if (!(full || (accept && last))) err_d = 1'b1;
            end else if (accept) begin
               state_d = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            state_d = ST_READY;
            if (bus.valid_i) err_d = 1'b1;
         end
         ST_READY: begin
            if (bus.ack_i) begin
               state_d = ST_IDLE;
               clr     = 1'b1;
               err_d   = 1'b0;
            end else if (bus.valid_i) begin
               err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         wr_en_q   <= accept;
         wr_addr_q <= addr;
         wr_data_q <= bus.data_i;
      end
   end

   assign bus.wr_en_o       = wr_en_q;
   assign bus.wr_addr_o     = wr_addr_q;
   assign bus.wr_data_o     = wr_data_q;
   assign bus.frame_ready_o = (state_q == ST_READY);
   assign bus.err_o         = err_q;
   assign bus.busy_o        = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
endmodule

// File: tb/tb_r8_result_collector.sv
// Directed, table-driven bench for r8_result_collector (4x3 frame) plus a default-size 19x19 run.
module tb_r8_result_collector;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   r8_result_collector_if #(.DATA_W(8), .ADDR_W(10)) rif ();
   r8_result_collector_if #(.DATA_W(8), .ADDR_W(10)) rif_d ();

   r8_result_collector #(.COLS(4), .ROWS(3), .DATA_W(8), .ADDR_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rif)
   );

   r8_result_collector dut_d (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rif_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       fe;
      logic       ack;
      logic       wr;
      int         addr;
      int         data;
      logic       rdy;
      logic       err;
      logic       busy;
      int         col;
      int         row;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic v, input int d, input logic fe, input logic ack,
                               input logic wr, input int addr, input int data,
                               input logic rdy, input logic err, input logic busy,
                               input int col, input int row);
      vec_t e;
      e.v = v; e.d = 8'(d); e.fe = fe; e.ack = ack;
      e.wr = wr; e.addr = addr; e.data = data;
      e.rdy = rdy; e.err = err; e.busy = busy; e.col = col; e.row = row;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic wr, input logic rdy, input logic err,
                          input logic busy, input int col, input int row);
      chk({tag, " wr_en"}, int'(rif.wr_en_o), int'(wr));
      chk({tag, " frame_ready"}, int'(rif.frame_ready_o), int'(rdy));
      chk({tag, " err"}, int'(rif.err_o), int'(err));
      chk({tag, " busy"}, int'(rif.busy_o), int'(busy));
      chk({tag, " col"}, int'(rif.col_o), col);
      chk({tag, " row"}, int'(rif.row_o), row);
   endtask

   task automatic drive(input logic v, input int d, input logic fe, input logic ack);
      rif.valid_i     = v;
      rif.data_i      = 8'(d);
      rif.frame_end_i = fe;
      rif.ack_i       = ack;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      rif.valid_i = 1'b0; rif.data_i = '0; rif.frame_end_i = 1'b0; rif.ack_i = 1'b0;
      rif_d.valid_i = 1'b0; rif_d.data_i = '0; rif_d.frame_end_i = 1'b0; rif_d.ack_i = 1'b0;

      // full frame, data 1..12
      for (int i = 0; i < 12; i++)
         add(1, i + 1, 0, 0, 1, i, i + 1, 0, 0, 1, (i + 1) % 4, (i + 1) / 4);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // short frame starting the cycle right after ack
      for (int i = 0; i < 11; i++)
         add(1, 101 + i, 0, 0, 1, i, 101 + i, 0, 0, 1, (i + 1) % 4, (i + 1) / 4);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // 12th pixel coincides with frame_end
      for (int i = 0; i < 11; i++)
         add(1, 50 + i, 0, 0, 1, i, 50 + i, 0, 0, 1, (i + 1) % 4, (i + 1) / 4);
      add(1, 61, 1, 0, 1, 11, 61, 0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // overlong frame: 13th pixel dropped
      for (int i = 0; i < 12; i++)
         add(1, 200 + i, 0, 0, 1, i, 200 + i, 0, 0, 1, (i + 1) % 4, (i + 1) / 4);
      add(1, 238, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // empty frame, then a pixel while READY
      add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // good frame, pixel during DRAIN, then ack together with a pixel
      for (int i = 0; i < 12; i++)
         add(1, 30 + i, 0, 0, 1, i, 30 + i, 0, 0, 1, (i + 1) % 4, (i + 1) / 4);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3);
      add(1, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3);
      add(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      chk("reset wr_addr", int'(rif.wr_addr_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[k]) begin
         drive(tbl[k].v, int'(tbl[k].d), tbl[k].fe, tbl[k].ack);
         chk_all($sformatf("vec%0d", k), tbl[k].wr, tbl[k].rdy, tbl[k].err, tbl[k].busy,
                 tbl[k].col, tbl[k].row);
         if (tbl[k].wr) begin
            chk($sformatf("vec%0d wr_addr", k), int'(rif.wr_addr_o), tbl[k].addr);
            chk($sformatf("vec%0d wr_data", k), int'(rif.wr_data_o), tbl[k].data);
         end
      end

      // mid-frame reset: outputs drop immediately, next frame restarts at addr 0
      for (int i = 0; i < 5; i++) drive(1, 70 + i, 0, 0);
      chk_all("pre_rst", 1, 0, 0, 1, 1, 1);
      rif.valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      chk("async_rst wr_addr", int'(rif.wr_addr_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         drive(1, 80 + i, 0, 0);
         chk($sformatf("post_rst%0d wr_addr", i), int'(rif.wr_addr_o), i);
         chk($sformatf("post_rst%0d wr_data", i), int'(rif.wr_data_o), 80 + i);
      end
      drive(0, 0, 1, 0);
      chk("post_rst drain ready", int'(rif.frame_ready_o), 0);
      drive(0, 0, 0, 0);
      chk_all("post_rst ready", 0, 1, 0, 0, 0, 3);
      drive(0, 0, 0, 1);

      // default 19x19 instance: 361 pixels, last address 360
      for (int i = 0; i < 361; i++) begin
         rif_d.valid_i = 1'b1;
         rif_d.data_i  = 8'(i);
         @(posedge clk);
         #1;
         chk($sformatf("dflt%0d wr_addr", i), int'(rif_d.wr_addr_o), i);
      end
      rif_d.valid_i     = 1'b0;
      rif_d.frame_end_i = 1'b1;
      @(posedge clk);
      #1;
      rif_d.frame_end_i = 1'b0;
      chk("dflt drain ready", int'(rif_d.frame_ready_o), 0);
      @(posedge clk);
      #1;
      chk("dflt ready", int'(rif_d.frame_ready_o), 1);
      chk("dflt err", int'(rif_d.err_o), 0);
      chk("dflt row", int'(rif_d.row_o), 19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
